// File: rtl/trig_conditioner.sv
// rtl/trig_conditioner.sv - trigger synchroniser, debouncer and hold-off gate for the pulse sequencer
// Build option: define TRIG_MISS_COUNT_EN to keep the missed-trigger counter; otherwise miss_count is tied to 0.
module trig_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 16,
  parameter int HOLDOFF     = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic             arm,
  input  logic             seq_busy,
  input  logic             cnt_clr,
  output logic             start,
  output logic             armed,
  output logic             trig_level,
  output logic [CNT_W-1:0] trig_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int HO_W = $clog2(HOLDOFF + 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("DEBOUNCE must be at least 1");
  end
  if (HOLDOFF < 2) begin : g_bad_holdoff
    $error("HOLDOFF must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DB_W-1:0]        db_cnt;
  logic                   level_q;
  logic                   rise;
  logic [HO_W-1:0]        hold_cnt;
  logic                   accept;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig};
    end
  end

  // The level only flips after the counter has been seen at DEBOUNCE with s still different.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt     <= '0;
      trig_level <= 1'b0;
      level_q    <= 1'b0;
    end else begin
      level_q <= trig_level;
      if (s == trig_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE)) begin
        trig_level <= s;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign rise   = trig_level & ~level_q;
  assign accept = (state == ARMED) && rise;

  // hold_cnt saturates at HOLDOFF so an arbitrarily long seq_busy cannot wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      start    <= 1'b0;
      armed    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state <= ARMED;
            armed <= 1'b1;
          end
        end
        ARMED: begin
          if (rise) begin
            start    <= 1'b1;
            hold_cnt <= '0;
            state    <= HOLD;
            armed    <= 1'b0;
          end else if (!arm) begin
            state <= IDLE;
            armed <= 1'b0;
          end
        end
        HOLD: begin
          if (hold_cnt != HO_W'(HOLDOFF)) begin
            hold_cnt <= hold_cnt + HO_W'(1);
          end
          if (hold_cnt == HO_W'(HOLDOFF) && !seq_busy) begin
            state <= arm ? ARMED : IDLE;
            armed <= arm;
          end
        end
        default: begin
          state <= IDLE;
          armed <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_count <= '0;
    end else if (cnt_clr) begin
      trig_count <= '0;
    end else if (accept && trig_count != {CNT_W{1'b1}}) begin
      trig_count <= trig_count + CNT_W'(1);
    end
  end

`ifdef TRIG_MISS_COUNT_EN
  logic miss_inc;
  assign miss_inc = (state == HOLD) && rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count <= '0;
    end else if (cnt_clr) begin
      miss_count <= '0;
    end else if (miss_inc && miss_count != {CNT_W{1'b1}}) begin
      miss_count <= miss_count + CNT_W'(1);
    end
  end
`else
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_trig_conditioner.sv
// tb/tb_trig_conditioner.sv - directed self-checking bench for trig_conditioner
module tb_trig_conditioner;

`ifdef TRIG_MISS_COUNT_EN
  localparam int MISS_ONE = 1;
`else
  localparam int MISS_ONE = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       trig;
  logic       arm;
  logic       seq_busy;
  logic       cnt_clr;
  logic       start;
  logic       armed;
  logic       trig_level;
  logic [7:0] trig_count;
  logic [7:0] miss_count;

  int checks;
  int failures;
  int starts;

  trig_conditioner #(
    .SYNC_STAGES(2),
    .DEBOUNCE   (4),
    .HOLDOFF    (10),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig      (trig),
    .arm       (arm),
    .seq_busy  (seq_busy),
    .cnt_clr   (cnt_clr),
    .start     (start),
    .armed     (armed),
    .trig_level(trig_level),
    .trig_count(trig_count),
    .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (start) starts++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    starts   = 0;
    rst_n    = 1'b0;
    trig     = 1'b0;
    arm      = 1'b0;
    seq_busy = 1'b0;
    cnt_clr  = 1'b0;
    tick();
    tick();
    tick();
    chk("reset_start", 32'(start), 0);
    chk("reset_armed", 32'(armed), 0);
    chk("reset_level", 32'(trig_level), 0);
    chk("reset_trig_count", 32'(trig_count), 0);
    chk("reset_miss_count", 32'(miss_count), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_not_armed", 32'(armed), 0);

    // basic trigger: start on the 8th edge counting the first sampling edge as 1
    arm = 1'b1;
    tick();
    chk("arm_latency", 32'(armed), 1);
    trig = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("basic_start_e%0d", k), 32'(start), 32'(k == 8));
      if (k == 6) chk("level_before_qual", 32'(trig_level), 0);
      if (k == 7) chk("level_after_qual", 32'(trig_level), 1);
    end
    chk("basic_trig_count", 32'(trig_count), 1);
    chk("hold_armed_e9", 32'(armed), 0);
    for (int j = 10; j <= 19; j++) begin
      tick();
      chk($sformatf("rearm_e%0d", j), 32'(armed), 32'(j == 19));
    end

    // glitch rejection
    trig = 1'b0;
    run(8);
    chk("level_fell", 32'(trig_level), 0);
    starts = 0;
    trig = 1'b1;
    run(3);
    trig = 1'b0;
    run(10);
    chk("glitch_level", 32'(trig_level), 0);
    chk("glitch_no_start", 32'(starts), 0);
    chk("glitch_trig_count", 32'(trig_count), 1);
    chk("glitch_miss_count", 32'(miss_count), 0);

    // hold-off miss with busy extension
    seq_busy = 1'b1;
    starts = 0;
    trig = 1'b1;
    run(8);
    chk("second_start", 32'(starts), 1);
    chk("second_trig_count", 32'(trig_count), 2);
    trig = 1'b0;
    run(8);
    trig = 1'b1;
    run(8);
    chk("miss_no_start", 32'(starts), 1);
    chk("miss_count_one", 32'(miss_count), MISS_ONE);
    trig = 1'b0;
    run(26);
    chk("busy_armed_low", 32'(armed), 0);
    seq_busy = 1'b0;
    tick();
    chk("busy_release_rearm", 32'(armed), 1);
    starts = 0;
    trig = 1'b1;
    run(8);
    chk("third_start", 32'(starts), 1);
    chk("third_trig_count", 32'(trig_count), 3);

    // disarm during hold-off
    arm = 1'b0;
    trig = 1'b0;
    run(20);
    chk("disarm_idle", 32'(armed), 0);
    starts = 0;
    trig = 1'b1;
    run(8);
    trig = 1'b0;
    run(8);
    chk("idle_no_start", 32'(starts), 0);
    chk("idle_no_miss", 32'(miss_count), MISS_ONE);
    chk("idle_trig_count", 32'(trig_count), 3);

    // clear coincident with start
    arm = 1'b1;
    tick();
    trig = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_start", 32'(start), 1);
    chk("clr_trig_count", 32'(trig_count), 0);
    chk("clr_miss_count", 32'(miss_count), 0);
    trig = 1'b0;
    run(20);

    // saturation
    starts = 0;
    for (int n = 0; n < 260; n++) begin
      trig = 1'b1;
      run(8);
      trig = 1'b0;
      run(16);
    end
    chk("sat_starts", 32'(starts), 260);
    chk("sat_trig_count", 32'(trig_count), 255);

    // reset mid-hold
    trig = 1'b1;
    seq_busy = 1'b1;
    run(8);
    run(3);
    rst_n = 1'b0;
    #1;
    chk("rst_start", 32'(start), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_level", 32'(trig_level), 0);
    chk("rst_trig_count", 32'(trig_count), 0);
    chk("rst_miss_count", 32'(miss_count), 0);
    tick();
    tick();
    seq_busy = 1'b0;
    rst_n = 1'b1;
    starts = 0;
    run(30);
    chk("post_rst_one_start", 32'(starts), 1);
    chk("post_rst_trig_count", 32'(trig_count), 1);
    chk("post_rst_level", 32'(trig_level), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
